// File: rtl/seven_seg_scan_if.sv
// Bus between the vending logic and the seven-segment scan scheduler.
// BRIGHTNESS_PWM_EN adds the brightness input to both modports.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    scan_en;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              data_out;
  logic [7:0]              display_column;
  logic                    frame_done;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]              brightness;

  modport master (
    output scan_en, digits_in, digit_en, brightness,
    input  data_out, display_column, frame_done
  );
  modport slave (
    input  scan_en, digits_in, digit_en, brightness,
    output data_out, display_column, frame_done
  );
`else
  modport master (
    output scan_en, digits_in, digit_en,
    input  data_out, display_column, frame_done
  );
  modport slave (
    input  scan_en, digits_in, digit_en,
    output data_out, display_column, frame_done
  );
`endif
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Frame-snapshotting scan scheduler for a multiplexed seven-segment display.
// Optional BRIGHTNESS_PWM_EN gates the active column with a 4-bit PWM.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 50000,
  parameter int BLANK      = 100
) (
  input logic             clk,
  input logic             reset,
  seven_seg_scan_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - BLANK - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHOW = 2'd1, ST_BLANK = 2'd2} state_t;

  state_t                  state_r;
  logic [IW-1:0]           idx_r;
  logic [CW-1:0]           cnt_r;
  logic [4*NUM_DIGITS-1:0] shadow_dig_r;
  logic [NUM_DIGITS-1:0]   shadow_en_r;
  logic [3:0]              data_r;
  logic [7:0]              col_r;
  logic                    done_r;

  logic [IW-1:0]           idx_nxt_s;
  logic                    slot_end_s;
  logic                    to_blank_s;
  logic                    pwm_on_s;

  // One-cold column mask; the selected bit goes low only when lit.
  function automatic logic [7:0] col_mask(input logic [IW-1:0] i, input logic lit);
    logic [7:0] m;
    m    = 8'hFF;
    m[i] = ~lit;
    return m;
  endfunction

`ifdef BRIGHTNESS_PWM_EN
  logic [3:0] pwm_cnt_r;
  logic [3:0] pwm_nxt_s;

  // Free-running PWM phase; gating uses the value the column register will be shown with.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_r <= 4'd0;
    end else begin
      pwm_cnt_r <= pwm_nxt_s;
    end
  end

  assign pwm_nxt_s = reset ? 4'd0 : (pwm_cnt_r + 4'd1);
  assign pwm_on_s  = (pwm_nxt_s <= bus.brightness);
`else
  assign pwm_on_s  = 1'b1;
`endif

  assign idx_nxt_s  = idx_r + IDX_ONE;
  assign slot_end_s = (cnt_r == SLOT_LAST);
  assign to_blank_s = (state_r == ST_SHOW) && (cnt_r == SHOW_LAST);

  // Scan FSM with registered column, data and frame pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      cnt_r        <= '0;
      shadow_dig_r <= '0;
      shadow_en_r  <= '0;
      data_r       <= 4'h0;
      col_r        <= 8'hFF;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          idx_r <= '0;
          if (bus.scan_en) begin
            shadow_dig_r <= bus.digits_in;
            shadow_en_r  <= bus.digit_en;
            data_r       <= bus.digits_in[3:0];
            col_r        <= col_mask('0, bus.digit_en[0] & pwm_on_s);
            state_r      <= ST_SHOW;
          end else begin
            col_r <= 8'hFF;
          end
        end
        ST_SHOW, ST_BLANK: begin
          if (slot_end_s) begin
            cnt_r <= '0;
            if (idx_r == IDX_LAST) begin
              done_r <= 1'b1;
              idx_r  <= '0;
              // Frame boundary: the only place the shadow copy may change.
              if (bus.scan_en) begin
                shadow_dig_r <= bus.digits_in;
                shadow_en_r  <= bus.digit_en;
                data_r       <= bus.digits_in[3:0];
                col_r        <= col_mask('0, bus.digit_en[0] & pwm_on_s);
                state_r      <= ST_SHOW;
              end else begin
                col_r   <= 8'hFF;
                state_r <= ST_IDLE;
              end
            end else begin
              idx_r   <= idx_nxt_s;
              data_r  <= shadow_dig_r[{idx_nxt_s, 2'b00} +: 4];
              col_r   <= col_mask(idx_nxt_s, shadow_en_r[idx_nxt_s] & pwm_on_s);
              state_r <= ST_SHOW;
            end
          end else if (to_blank_s) begin
            cnt_r   <= cnt_r + CNT_ONE;
            col_r   <= 8'hFF;
            state_r <= ST_BLANK;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (state_r == ST_SHOW) begin
              col_r <= col_mask(idx_r, shadow_en_r[idx_r] & pwm_on_s);
            end else begin
              col_r <= 8'hFF;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
          cnt_r   <= '0;
          col_r   <= 8'hFF;
        end
      endcase
    end
  end

  assign bus.data_out       = data_r;
  assign bus.display_column = col_r;
  assign bus.frame_done     = done_r;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized plus directed bench for seven_seg_scan_ctrl against a frame-position reference model.
module tb_seven_seg_scan_ctrl;
  localparam int ND = 8;
  localparam int DV = 10;
  localparam int BK = 2;
  localparam int FRAME = ND * DV;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  seven_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV), .BLANK(BK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: position within the current frame and its snapshot.
  logic        m_running;
  int          m_k;
  logic [31:0] m_dig;
  logic [7:0]  m_en;
  logic [3:0]  m_data;
  logic [7:0]  m_col;
  logic        m_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  // Advance the model on every edge and compare outputs just after it.
  always @(posedge clk) begin
    int         slot;
    int         pos;
    logic [7:0] one;
    #1;
    m_done = 1'b0;
    if (reset) begin
      m_running = 1'b0;
      m_k       = 0;
      m_dig     = 32'h0;
      m_en      = 8'h0;
      m_data    = 4'h0;
    end else if (!m_running) begin
      if (bus.scan_en) begin
        m_running = 1'b1;
        m_k       = 0;
        m_dig     = bus.digits_in;
        m_en      = bus.digit_en;
      end
    end else begin
      m_k = m_k + 1;
      if (m_k == FRAME) begin
        m_done = 1'b1;
        if (bus.scan_en) begin
          m_k   = 0;
          m_dig = bus.digits_in;
          m_en  = bus.digit_en;
        end else begin
          m_running = 1'b0;
        end
      end
    end
    m_col = 8'hFF;
    if (m_running) begin
      slot   = m_k / DV;
      pos    = m_k % DV;
      one    = 8'h01;
      m_data = m_dig[4*slot +: 4];
      if (pos < DV - BK && m_en[slot]) m_col = ~(one << slot);
    end
    check_eq("column", {24'h0, bus.display_column}, {24'h0, m_col});
    check_eq("data", {28'h0, bus.data_out}, {28'h0, m_data});
    check_eq("frame_done", {31'h0, bus.frame_done}, {31'h0, m_done});
  end

  task automatic wait_frame_pos(input int kk, input string tag);
    int t;
    t = 0;
    while (!(m_running && m_k == kk) && t < 4 * FRAME) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, {31'h0, (t < 4 * FRAME)}, 32'h1);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    m_running     = 1'b0;
    m_k           = 0;
    reset         = 1'b1;
    bus.scan_en   = 1'b0;
    bus.digits_in = 32'h0;
    bus.digit_en  = 8'h00;
`ifdef BRIGHTNESS_PWM_EN
    bus.brightness = 4'd15;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Full frames with all digits enabled.
    bus.digits_in = 32'h76543210;
    bus.digit_en  = 8'hFF;
    bus.scan_en   = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    // Reset in the middle of a SHOW window, then idle.
    wait_frame_pos(3, "wait_show");
    reset       = 1'b1;
    bus.scan_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Alternate digits disabled.
    bus.digit_en = 8'b1010_1010;
    bus.scan_en  = 1'b1;
    repeat (FRAME + 3) @(negedge clk);

    // Mid-frame data change is deferred to the next frame.
    wait_frame_pos(30, "wait_k30");
    bus.digits_in = 32'h99999999;
    bus.digit_en  = 8'hFF;
    wait_frame_pos(40, "wait_next_k40");
    wait_frame_pos(39, "wait_k39");
    bus.scan_en = 1'b0;
    repeat (FRAME) @(negedge clk);

    // Randomized traffic with occasional resets and scan_en drops.
    bus.scan_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      bus.scan_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) bus.digits_in = $urandom;
      if ($urandom_range(0, 19) == 0) bus.digit_en = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
